// File: rtl/keyboard_buffer_pkg.sv
// Shared constants for the keyboard buffer: register map, STATUS bit positions, bus FSM states.
package keyboard_buffer_pkg;

    localparam logic [1:0] KBB_DATA   = 2'd0;
    localparam logic [1:0] KBB_STATUS = 2'd1;
    localparam logic [1:0] KBB_OVRCNT = 2'd2;

    localparam int STAT_RDY    = 0;
    localparam int STAT_OVR    = 1;
    localparam int STAT_INT_EN = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        HOLD = 2'd2
    } bus_state_t;

endpackage

// File: rtl/kbd_fifo.sv
// Keycode FIFO: power-of-2 depth, wrapping pointers, simultaneous push+pop accepted even when full.
module kbd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_count,
    output logic             o_push_drop
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_pop_ok;
    logic w_push_ok;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == FULL_CNT);
    assign o_count   = r_count;
    assign w_pop_ok  = i_pop & ~o_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_push_ok = i_push & (~o_full | w_pop_ok);
    assign o_push_drop = i_push & ~w_push_ok;
    assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/keyboard_buffer.sv
// Keyboard keycode buffer with a 4-register bus slave, sticky overrun and level irq.
// Optional dropped-push counter at address 2 enabled by KEYBOARD_BUFFER_OVRCNT_EN.
import keyboard_buffer_pkg::*;

module keyboard_buffer #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] kb_data,
    input  logic        kb_strobe,
    input  logic [1:0]  bus_addr,
    input  logic        bus_rd,
    input  logic        bus_wr,
    input  logic [15:0] bus_wdata,
    output logic [15:0] bus_rdata,
    output logic        bus_ack,
    output logic        irq
);

    localparam int AW = $clog2(DEPTH);

    bus_state_t  r_state;
    logic        r_strobe_prev;
    logic        r_int_en;
    logic        r_overrun;
    logic        r_ack;
    logic        r_irq;
    logic [15:0] r_rdata;

    logic        w_push;
    logic        w_pop;
    logic        w_drop;
    logic        w_full;
    logic        w_empty;
    logic        w_rdy;
    logic [AW:0] w_count;
    logic [15:0] w_head;
    logic        w_req;
    logic        w_rd;
    logic        w_wr;
    logic        w_stat_wr;
    logic        w_ovr_clr;
    logic [15:0] w_status;
    logic [15:0] w_ovrcnt_val;
    logic [15:0] w_rd_val;
    logic        w_unused;

    assign w_push = kb_strobe & ~r_strobe_prev;
    assign w_req  = bus_rd | bus_wr;
    // Requests only act in IDLE; a simultaneous rd and wr is a read.
    assign w_rd   = (r_state == IDLE) & bus_rd;
    assign w_wr   = (r_state == IDLE) & bus_wr & ~bus_rd;
    assign w_pop  = w_rd & (bus_addr == KBB_DATA);

    assign w_stat_wr = w_wr & (bus_addr == KBB_STATUS);
    assign w_ovr_clr = w_stat_wr & bus_wdata[STAT_OVR];
    assign w_rdy     = ~w_empty;
    assign w_status  = {8'(w_count), 5'b0, r_int_en, r_overrun, w_rdy};
    assign w_unused  = ^{bus_wdata[15:3], bus_wdata[0], w_full};

    kbd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (kb_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count),
        .o_push_drop (w_drop)
    );

`ifdef KEYBOARD_BUFFER_OVRCNT_EN
    logic [7:0] r_ovrcnt;
    logic       w_ovrcnt_clr;

    assign w_ovrcnt_clr = w_wr & (bus_addr == KBB_OVRCNT);
    assign w_ovrcnt_val = {8'b0, r_ovrcnt};

    always_ff @(posedge clk) begin
        if (reset || w_ovrcnt_clr) begin
            r_ovrcnt <= '0;
        end else if (w_drop && (r_ovrcnt != 8'hFF)) begin
            r_ovrcnt <= r_ovrcnt + 8'd1;
        end
    end
`else
    assign w_ovrcnt_val = 16'h0000;
`endif

    always_comb begin
        w_rd_val = 16'h0000;
        case (bus_addr)
            KBB_DATA:   w_rd_val = w_head;
            KBB_STATUS: w_rd_val = w_status;
            KBB_OVRCNT: w_rd_val = w_ovrcnt_val;
            default:    w_rd_val = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_strobe_prev <= 1'b0;
            r_int_en      <= 1'b0;
            r_overrun     <= 1'b0;
            r_ack         <= 1'b0;
            r_irq         <= 1'b0;
            r_rdata       <= 16'h0000;
        end else begin
            r_strobe_prev <= kb_strobe;
            r_ack         <= 1'b0;
            r_rdata       <= 16'h0000;
            r_irq         <= r_int_en & w_rdy;

            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_state <= ACK;
                        r_ack   <= 1'b1;
                        if (bus_rd) r_rdata <= w_rd_val;
                    end
                end
                ACK:     r_state <= HOLD;
                HOLD:    if (!w_req) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase

            if (w_stat_wr) r_int_en <= bus_wdata[STAT_INT_EN];

            // A new overrun beats a clear in the same cycle.
            if (w_drop)         r_overrun <= 1'b1;
            else if (w_ovr_clr) r_overrun <= 1'b0;
        end
    end

    assign bus_ack   = r_ack;
    assign bus_rdata = r_rdata;
    assign irq       = r_irq;

endmodule

// File: tb/tb_keyboard_buffer.sv
// Directed scoreboard bench for keyboard_buffer; one line per bus transaction.
module tb_keyboard_buffer;
    import keyboard_buffer_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] kb_data = '0;
    logic        kb_strobe = 1'b0;
    logic [1:0]  bus_addr = '0;
    logic        bus_rd = 1'b0;
    logic        bus_wr = 1'b0;
    logic [15:0] bus_wdata = '0;
    logic [15:0] bus_rdata;
    logic        bus_ack;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] sb[$];
    logic        m_int_en = 1'b0;
    logic        m_ovr = 1'b0;
    int          m_ovrcnt = 0;

    keyboard_buffer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .kb_data   (kb_data),
        .kb_strobe (kb_strobe),
        .bus_addr  (bus_addr),
        .bus_rd    (bus_rd),
        .bus_wr    (bus_wr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_status();
        return {8'(sb.size()), 5'b0, m_int_en, m_ovr, sb.size() != 0};
    endfunction

    task automatic model_push(input logic [15:0] d);
        if (sb.size() < DEPTH) begin
            sb.push_back(d);
        end else begin
            m_ovr = 1'b1;
            if (m_ovrcnt < 255) m_ovrcnt++;
        end
    endtask

    task automatic strobe(input logic [15:0] d);
        kb_data   = d;
        kb_strobe = 1'b1;
        model_push(d);
        tick();
        kb_strobe = 1'b0;
        tick();
    endtask

    task automatic bus_cycle(input logic rd, input logic [1:0] a, input logic [15:0] wd,
                             output logic [15:0] rdv);
        int lat;
        lat = 0;
        bus_addr  = a;
        bus_wdata = wd;
        bus_rd    = rd;
        bus_wr    = ~rd;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (bus_ack) begin
                lat = i;
                break;
            end
        end
        check("ack_latency", 16'(lat), 16'd1);
        rdv    = bus_rdata;
        bus_rd = 1'b0;
        bus_wr = 1'b0;
        tick();
        check("ack_one_cycle", {15'b0, bus_ack}, 16'd0);
        check("rdata_idle_zero", bus_rdata, 16'h0000);
        tick();
    endtask

    task automatic rd_reg(input string tag, input logic [1:0] a, input logic [15:0] exp);
        logic [15:0] v;
        bus_cycle(1'b1, a, 16'h0000, v);
        $display("RD addr=%0d data=%h exp=%h (%s)", a, v, exp, tag);
        check(tag, v, exp);
    endtask

    task automatic rd_data(input string tag);
        logic [15:0] exp;
        exp = (sb.size() != 0) ? sb.pop_front() : 16'h0000;
        rd_reg(tag, KBB_DATA, exp);
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [15:0] d);
        logic [15:0] v;
        if (a == KBB_STATUS) begin
            m_int_en = d[2];
            if (d[1]) m_ovr = 1'b0;
        end
        if (a == KBB_OVRCNT) m_ovrcnt = 0;
        bus_cycle(1'b0, a, d, v);
        $display("WR addr=%0d data=%h", a, d);
    endtask

    initial begin
        logic [15:0] exp;
        int acks;

        // Reset state
        tick();
        tick();
        check("reset_ack", {15'b0, bus_ack}, 16'd0);
        check("reset_rdata", bus_rdata, 16'h0000);
        check("reset_irq", {15'b0, irq}, 16'd0);
        reset = 1'b0;
        tick();
        rd_reg("reset_status", KBB_STATUS, 16'h0000);

        // 1: single keycode
        strobe(16'h0041);
        rd_reg("t1_status", KBB_STATUS, exp_status());
        rd_data("t1_data");
        rd_reg("t1_status_empty", KBB_STATUS, exp_status());

        // 2: overflow by one, drain, clear overrun
        for (int i = 1; i <= 9; i++) strobe(16'(i));
        rd_reg("t2_status_full", KBB_STATUS, exp_status());
        for (int i = 0; i < 8; i++) rd_data("t2_data");
        wr_reg(KBB_STATUS, 16'h0002);
        rd_reg("t2_status_clr", KBB_STATUS, exp_status());

        // 3: interrupt timing
        wr_reg(KBB_STATUS, 16'h0004);
        kb_data   = 16'h0055;
        kb_strobe = 1'b1;
        model_push(16'h0055);
        tick();
        check("t3_irq_lag", {15'b0, irq}, 16'd0);
        kb_strobe = 1'b0;
        tick();
        check("t3_irq_set", {15'b0, irq}, 16'd1);
        exp = sb.pop_front();
        bus_addr = KBB_DATA;
        bus_rd   = 1'b1;
        tick();
        check("t3_ack", {15'b0, bus_ack}, 16'd1);
        check("t3_data", bus_rdata, exp);
        check("t3_irq_at_ack", {15'b0, irq}, 16'd1);
        $display("RD addr=0 data=%h exp=%h (t3_data)", bus_rdata, exp);
        bus_rd = 1'b0;
        tick();
        check("t3_irq_drop", {15'b0, irq}, 16'd0);
        tick();

        // 4: held read pops once
        for (int i = 0; i < 3; i++) strobe(16'h0A00 + 16'(i));
        exp  = sb.pop_front();
        acks = 0;
        bus_addr = KBB_DATA;
        bus_rd   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus_ack) begin
                acks++;
                check("t4_data", bus_rdata, exp);
                $display("RD addr=0 data=%h exp=%h (t4_held)", bus_rdata, exp);
            end
        end
        bus_rd = 1'b0;
        tick();
        tick();
        check("t4_ack_count", 16'(acks), 16'd1);
        rd_reg("t4_status", KBB_STATUS, exp_status());
        rd_data("t4_drain");
        rd_data("t4_drain");

        // 5: push and pop together on a full FIFO
        for (int i = 0; i < 8; i++) strobe(16'h0100 + 16'(i));
        exp = sb.pop_front();
        model_push(16'h0200);
        kb_data   = 16'h0200;
        kb_strobe = 1'b1;
        bus_addr  = KBB_DATA;
        bus_rd    = 1'b1;
        tick();
        check("t5_ack", {15'b0, bus_ack}, 16'd1);
        check("t5_data", bus_rdata, exp);
        $display("RD addr=0 data=%h exp=%h (t5_simul)", bus_rdata, exp);
        kb_strobe = 1'b0;
        bus_rd    = 1'b0;
        tick();
        tick();
        rd_reg("t5_status", KBB_STATUS, exp_status());
        for (int i = 0; i < 8; i++) rd_data("t5_order");
        rd_data("t5_empty_read");

        // 6: overrun counter / unused addresses
`ifdef KEYBOARD_BUFFER_OVRCNT_EN
        m_ovrcnt = 0;
        wr_reg(KBB_OVRCNT, 16'h0000);
        for (int i = 0; i < 8; i++) strobe(16'h0300 + 16'(i));
        for (int i = 0; i < 300; i++) strobe(16'hDEAD);
        rd_reg("t6_ovrcnt_sat", KBB_OVRCNT, 16'(m_ovrcnt));
        wr_reg(KBB_OVRCNT, 16'h1234);
        rd_reg("t6_ovrcnt_clr", KBB_OVRCNT, 16'(m_ovrcnt));
        for (int i = 0; i < 8; i++) rd_data("t6_drain");
`else
        strobe(16'h0777);
        wr_reg(KBB_OVRCNT, 16'hFFFF);
        rd_reg("t6_addr2_zero", KBB_OVRCNT, 16'h0000);
        rd_data("t6_drain");
`endif
        wr_reg(2'd3, 16'hFFFF);
        rd_reg("t6_addr3_zero", 2'd3, 16'h0000);

        // Reset while HOLD with irq high
        wr_reg(KBB_STATUS, 16'h0004);
        strobe(16'h00AA);
        bus_addr = KBB_STATUS;
        bus_rd   = 1'b1;
        tick();
        check("rst_pre_ack", {15'b0, bus_ack}, 16'd1);
        tick();
        check("rst_pre_irq", {15'b0, irq}, 16'd1);
        reset = 1'b1;
        tick();
        check("rst_ack", {15'b0, bus_ack}, 16'd0);
        check("rst_rdata", bus_rdata, 16'h0000);
        check("rst_irq", {15'b0, irq}, 16'd0);
        reset  = 1'b0;
        bus_rd = 1'b0;
        sb.delete();
        m_int_en = 1'b0;
        m_ovr    = 1'b0;
        m_ovrcnt = 0;
        tick();
        rd_reg("rst_status", KBB_STATUS, exp_status());
        rd_data("rst_empty_read");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
